// File: rtl/nn_pkg.sv
// Shared fixed-point constants, layer sequencer states and saturating arithmetic
// for the neural-network datapath.
package nn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int INT_WIDTH  = 4;
  localparam int SAT_MAX_W  = 64;

  localparam logic signed [SAT_MAX_W:0] SAT_ONE = {{SAT_MAX_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_MAC,
    S_DRAIN,
    S_EMIT,
    S_DONE
  } state_t;

  // Address width that never collapses to zero bits for single-entry memories.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Signed add clamped to the range of a `width`-bit two's-complement value
  // (width <= SAT_MAX_W); operands arrive sign-extended to SAT_MAX_W bits.
  function automatic logic signed [SAT_MAX_W-1:0] sat_add(
      input logic signed [SAT_MAX_W-1:0] a,
      input logic signed [SAT_MAX_W-1:0] b,
      input int                          width);
    logic signed [SAT_MAX_W:0] sum;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    sum = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
    hi  = (SAT_ONE <<< (width - 1)) - SAT_ONE;
    lo  = -(SAT_ONE <<< (width - 1));
    if (sum > hi) begin
      return SAT_MAX_W'(hi);
    end else if (sum < lo) begin
      return SAT_MAX_W'(lo);
    end
    return SAT_MAX_W'(sum);
  endfunction

endpackage

// File: rtl/neuron_layer_sequencer_if.sv
// Controller, memory and ReLU-stage signals of one fully-connected layer sequencer.
interface neuron_layer_sequencer_if #(
  parameter int dataWidth  = 16,
  parameter int numInputs  = 784,
  parameter int numNeurons = 30
);
  import nn_pkg::*;

  localparam int NA_W = addr_w(numNeurons);
  localparam int IA_W = addr_w(numInputs);

  logic                          start;
  logic                          stall;
  logic                          busy;
  logic                          done;
  logic                          mem_rd_en;
  logic [NA_W-1:0]               neuron_addr;
  logic [IA_W-1:0]               input_addr;
  logic signed [dataWidth-1:0]   x_data;
  logic signed [dataWidth-1:0]   w_data;
  logic signed [2*dataWidth-1:0] b_data;
  logic                          relu_valid;
  logic signed [2*dataWidth-1:0] relu_in;
  logic [NA_W-1:0]               relu_neuron;

  modport master (
    output start, stall, x_data, w_data, b_data,
    input  busy, done, mem_rd_en, neuron_addr, input_addr,
    input  relu_valid, relu_in, relu_neuron
  );

  modport slave (
    input  start, stall, x_data, w_data, b_data,
    output busy, done, mem_rd_en, neuron_addr, input_addr,
    output relu_valid, relu_in, relu_neuron
  );

endinterface

// File: rtl/mac_unit.sv
// Signed multiplier feeding a saturating accumulator; clr beats load beats acc_en.
module mac_unit
  import nn_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_clr,
  input  logic                        i_load,
  input  logic                        i_acc_en,
  input  logic signed [DATA_W-1:0]    i_x,
  input  logic signed [DATA_W-1:0]    i_w,
  input  logic signed [2*DATA_W-1:0]  i_bias,
  output logic signed [2*DATA_W-1:0]  o_acc
);

  localparam int ACC_W = 2 * DATA_W;

  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] r_acc;

  // A full-width signed product of two DATA_W operands always fits in ACC_W bits.
  assign w_prod = ACC_W'(i_x) * ACC_W'(i_w);
  assign w_sum  = ACC_W'(sat_add(SAT_MAX_W'(r_acc), SAT_MAX_W'(w_prod), ACC_W));

  // NOTE: flops are written with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_bias;
    end else if (i_acc_en) begin
      r_acc <= w_sum;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Walks every neuron of a fully-connected layer through bias fetch, MAC and emit,
// handing each saturated accumulator to the ReLU stage.
module neuron_layer_sequencer
  import nn_pkg::*;
#(
  parameter int dataWidth  = DATA_WIDTH,
  parameter int intWidth   = INT_WIDTH,
  parameter int numInputs  = 784,
  parameter int numNeurons = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  neuron_layer_sequencer_if.slave  bus
);

  localparam int NA_W = addr_w(numNeurons);
  localparam int IA_W = addr_w(numInputs);

  localparam logic [NA_W-1:0] NA_LAST = NA_W'(numNeurons - 1);
  localparam logic [IA_W-1:0] IA_LAST = IA_W'(numInputs - 1);

  if (numInputs < 2 || numNeurons < 1 || intWidth > dataWidth - 1) begin : g_param_check
    $error("neuron_layer_sequencer: unsupported parameter combination");
  end

  state_t          r_state;
  logic [NA_W-1:0] r_neuron;
  logic [IA_W-1:0] r_input;
  logic            r_busy;
  logic            r_done;
  logic            r_rd_phase;
  logic            r_emit;

  logic                          w_hold;
  logic                          w_mac_clr;
  logic                          w_mac_load;
  logic                          w_mac_acc_en;
  logic signed [2*dataWidth-1:0] w_acc;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_hold       = 1'b0;
    w_mac_clr    = 1'b0;
    w_mac_load   = 1'b0;
    w_mac_acc_en = 1'b0;
    case (r_state)
      S_IDLE: w_mac_clr = bus.start;
      S_BIAS, S_EMIT: w_hold = bus.stall;
      S_MAC: begin
        w_hold       = bus.stall;
        w_mac_load   = !bus.stall && (r_input == '0);
        w_mac_acc_en = !bus.stall && (r_input != '0);
      end
      S_DRAIN: begin
        w_hold       = bus.stall;
        w_mac_acc_en = !bus.stall;
      end
      default: ;
    endcase
  end

  // Status flags are registered alongside the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_neuron   <= '0;
      r_input    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_phase <= 1'b0;
      r_emit     <= 1'b0;
    end else if (!w_hold) begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_BIAS;
            r_neuron   <= '0;
            r_input    <= '0;
            r_busy     <= 1'b1;
            r_rd_phase <= 1'b1;
          end
        end
        S_BIAS: r_state <= S_MAC;
        S_MAC: begin
          if (r_input == IA_LAST) begin
            r_state    <= S_DRAIN;
            r_input    <= '0;
            r_rd_phase <= 1'b0;
          end else begin
            r_input <= r_input + IA_W'(1);
          end
        end
        S_DRAIN: begin
          r_state <= S_EMIT;
          r_emit  <= 1'b1;
        end
        S_EMIT: begin
          r_emit <= 1'b0;
          if (r_neuron == NA_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_BIAS;
            r_neuron   <= r_neuron + NA_W'(1);
            r_rd_phase <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  mac_unit #(
    .DATA_W (dataWidth)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_mac_clr),
    .i_load   (w_mac_load),
    .i_acc_en (w_mac_acc_en),
    .i_x      (bus.x_data),
    .i_w      (bus.w_data),
    .i_bias   (bus.b_data),
    .o_acc    (w_acc)
  );

  // stall is the only input allowed to reach outputs combinationally.
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.mem_rd_en   = r_rd_phase && !bus.stall;
  assign bus.relu_valid  = r_emit && !bus.stall;
  assign bus.neuron_addr = r_neuron;
  assign bus.input_addr  = r_input;
  assign bus.relu_neuron = r_neuron;
  assign bus.relu_in     = w_acc;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Self-checking bench: synchronous memory model, event monitor and a cycle-level
// reference model of the layer (work-cycle counting plus clamped dot products).
module tb_neuron_layer_sequencer;

  localparam int DW   = 16;
  localparam int NI   = 4;
  localparam int NN   = 2;
  localparam int PER  = NI + 3;
  localparam int WORK = NN * PER;
  localparam int MAXC = 64;

  typedef struct {
    int          cycle;
    int          neuron;
    logic [31:0] value;
  } relu_ev_t;

  logic clk = 1'b0;
  logic rst;

  neuron_layer_sequencer_if #(.dataWidth(DW), .numInputs(NI), .numNeurons(NN)) bus ();

  neuron_layer_sequencer #(
    .dataWidth (DW),
    .intWidth  (4),
    .numInputs (NI),
    .numNeurons(NN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic signed [15:0] x_mem [NI];
  logic signed [15:0] w_mem [NN][NI];
  logic signed [31:0] b_mem [NN];

  // Synchronous memories: data follows a read by one cycle and holds otherwise.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.x_data <= '0;
      bus.w_data <= '0;
      bus.b_data <= '0;
    end else if (bus.mem_rd_en) begin
      bus.x_data <= x_mem[bus.input_addr];
      bus.w_data <= w_mem[bus.neuron_addr][bus.input_addr];
      bus.b_data <= b_mem[bus.neuron_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  bit stall_pat [MAXC];
  int start_hold;
  int rst_cycle;

  relu_ev_t obs_q[$];
  relu_ev_t exp_q[$];
  int       obs_done[$];
  int       obs_rd;
  int       gate_viol;
  logic     last_busy;
  bit       mon_en = 1'b0;
  time      t0;
  int       mon_k;

  // Cycle k is the interval after edge k-1; edge 0 samples start.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_k = int'(($time - t0 - 5) / 10) + 1;
      if (bus.relu_valid) obs_q.push_back('{mon_k, int'(bus.relu_neuron), bus.relu_in});
      if (bus.done) obs_done.push_back(mon_k);
      if (bus.mem_rd_en) obs_rd++;
      if (bus.stall && bus.busy && (bus.mem_rd_en || bus.relu_valid)) gate_viol++;
      last_busy = bus.busy;
    end
  end

  function automatic logic [31:0] ref_neuron(input int n);
    longint acc;
    acc = longint'(b_mem[n]);
    for (int i = 0; i < NI; i++) begin
      acc = acc + longint'(x_mem[i]) * longint'(w_mem[n][i]);
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    end
    return 32'(acc);
  endfunction

  // Each unstalled busy cycle advances one slot of work; slot NI+2 of a neuron emits.
  task automatic build_expected(output int exp_done, output int exp_rd);
    int work;
    exp_q.delete();
    exp_done = -1;
    exp_rd   = 0;
    work     = 0;
    for (int k = 1; k < MAXC && work < WORK; k++) begin
      if (rst_cycle > 0 && k >= rst_cycle) break;
      if (stall_pat[k]) continue;
      if (work % PER <= NI) exp_rd++;
      if (work % PER == NI + 2) exp_q.push_back('{k, work / PER, ref_neuron(work / PER)});
      work++;
      if (work == WORK) exp_done = k + 1;
    end
    if (rst_cycle > 0 && exp_done >= rst_cycle) exp_done = -1;
  endtask

  task automatic set_defaults();
    for (int k = 0; k < MAXC; k++) stall_pat[k] = 1'b0;
    start_hold = 0;
    rst_cycle  = 0;
    for (int n = 0; n < NN; n++) begin
      b_mem[n] = '0;
      for (int i = 0; i < NI; i++) w_mem[n][i] = 16'sh0800;
    end
    for (int i = 0; i < NI; i++) x_mem[i] = 16'sh0800;
  endtask

  task automatic run_layer(input string name);
    int exp_done;
    int exp_rd;
    int ncyc;
    build_expected(exp_done, exp_rd);
    ncyc = ((exp_done > rst_cycle) ? exp_done : rst_cycle) + 2;
    obs_q.delete();
    obs_done.delete();
    obs_rd    = 0;
    gate_viol = 0;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.stall = 1'b0;
    @(posedge clk);
    t0     = $time;
    mon_en = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      #1;
      bus.start = (k <= start_hold);
      bus.stall = stall_pat[k];
      rst       = (k == rst_cycle);
      if (k == rst_cycle) begin
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.mem_rd_en, bus.relu_valid, bus.relu_in,
             bus.relu_neuron, bus.neuron_addr, bus.input_addr} !== 40'd0) begin
          failures++;
          $display("FAIL %s rst_outputs: got busy=%b done=%b rd=%b v=%b in=%h n=%0d na=%0d ia=%0d required all zero",
                   name, bus.busy, bus.done, bus.mem_rd_en, bus.relu_valid, bus.relu_in,
                   bus.relu_neuron, bus.neuron_addr, bus.input_addr);
        end
      end
      @(posedge clk);
    end
    mon_en    = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    rst       = 1'b0;

    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s relu_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].cycle != exp_q[i].cycle || obs_q[i].neuron != exp_q[i].neuron ||
          obs_q[i].value !== exp_q[i].value) begin
        failures++;
        $display("FAIL %s relu[%0d]: got cycle=%0d neuron=%0d value=%h required cycle=%0d neuron=%0d value=%h",
                 name, i, obs_q[i].cycle, obs_q[i].neuron, obs_q[i].value,
                 exp_q[i].cycle, exp_q[i].neuron, exp_q[i].value);
      end
    end
    checks++;
    if (obs_done.size() != ((exp_done > 0) ? 1 : 0) ||
        (exp_done > 0 && obs_done.size() == 1 && obs_done[0] != exp_done)) begin
      failures++;
      $display("FAIL %s done: got %0d pulses (first cycle %0d) required cycle %0d",
               name, obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, exp_done);
    end
    checks++;
    if (obs_rd != exp_rd) begin
      failures++;
      $display("FAIL %s mem_rd_en_cycles: got %0d required %0d", name, obs_rd, exp_rd);
    end
    checks++;
    if (gate_viol != 0) begin
      failures++;
      $display("FAIL %s stall_gating: got %0d strobes while stalled required 0", name, gate_viol);
    end
    checks++;
    if (last_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_at_end: got busy=%b required 0", name, last_busy);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.mem_rd_en, bus.relu_valid, bus.relu_in,
         bus.relu_neuron, bus.neuron_addr, bus.input_addr} !== 40'd0) begin
      failures++;
      $display("FAIL reset_state: got busy=%b done=%b rd=%b v=%b in=%h required all zero",
               bus.busy, bus.done, bus.mem_rd_en, bus.relu_valid, bus.relu_in);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_basic_sum();
    set_defaults();
    run_layer("basic");
    checks++;
    if (obs_q.size() < 2 || obs_q[0].cycle != 7 || obs_q[1].cycle != 14 ||
        obs_q[0].value !== 32'h0100_0000 || obs_q[1].value !== 32'h0100_0000) begin
      failures++;
      $display("FAIL basic_literal: got %0d results (first %h) required 0x01000000 at cycles 7 and 14",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].value : 32'hx);
    end
  endtask

  task automatic test_bias();
    set_defaults();
    b_mem[1] = 32'sh0020_0000;
    run_layer("bias");
    checks++;
    if (obs_q.size() < 2 || obs_q[1].value !== 32'h0120_0000) begin
      failures++;
      $display("FAIL bias_literal: got %0d results (last %h) required neuron 1 = 0x01200000",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1].value : 32'hx);
    end
  endtask

  task automatic test_saturation();
    set_defaults();
    for (int i = 0; i < NI; i++) begin
      x_mem[i]    = 16'sh7FFF;
      w_mem[0][i] = 16'sh7FFF;
      w_mem[1][i] = 16'sh7FFF;
    end
    run_layer("sat_pos");
    checks++;
    if (obs_q.size() < 1 || obs_q[0].value !== 32'h7FFF_FFFF) begin
      failures++;
      $display("FAIL sat_pos_literal: got %h required 7fffffff",
               (obs_q.size() > 0) ? obs_q[0].value : 32'hx);
    end
    set_defaults();
    for (int i = 0; i < NI; i++) begin
      w_mem[0][i] = 16'shF800;
      w_mem[1][i] = 16'shF800;
    end
    run_layer("neg_weights");
    checks++;
    if (obs_q.size() < 1 || obs_q[0].value !== 32'hFF00_0000) begin
      failures++;
      $display("FAIL neg_weights_literal: got %h required ff000000",
               (obs_q.size() > 0) ? obs_q[0].value : 32'hx);
    end
  endtask

  task automatic test_stall();
    set_defaults();
    stall_pat[3]  = 1'b1;
    stall_pat[4]  = 1'b1;
    stall_pat[5]  = 1'b1;
    stall_pat[10] = 1'b1;
    run_layer("stall");
    checks++;
    if (obs_done.size() != 1 || obs_done[0] != 19) begin
      failures++;
      $display("FAIL stall_done_literal: got %0d pulses (first %0d) required cycle 19",
               obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1);
    end
  endtask

  task automatic test_reset_mid_layer();
    set_defaults();
    rst_cycle = 9;
    run_layer("rst_mid");
    set_defaults();
    run_layer("after_rst");
  endtask

  task automatic test_ignored_start();
    set_defaults();
    start_hold = 15;
    run_layer("start_held");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      set_defaults();
      for (int n = 0; n < NN; n++) b_mem[n] = 32'($urandom);
      for (int i = 0; i < NI; i++) begin
        case (it % 3)
          0: x_mem[i] = 16'($urandom);
          default: x_mem[i] = 16'($urandom_range(32'h4000, 32'h7FFF));
        endcase
        for (int n = 0; n < NN; n++) begin
          case (it % 3)
            0: w_mem[n][i] = 16'($urandom);
            1: w_mem[n][i] = 16'($urandom_range(32'h4000, 32'h7FFF));
            default: w_mem[n][i] = 16'(-int'($urandom_range(32'h4000, 32'h7FFF)));
          endcase
        end
      end
      for (int k = 1; k <= 30; k++) stall_pat[k] = ($urandom_range(0, 3) == 0);
      run_layer($sformatf("random%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_bias();
    test_saturation();
    test_stall();
    test_reset_mid_layer();
    test_ignored_start();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
